// File: rtl/slt_seq_compare.sv
// slt_seq_compare: bit-serial SLT/SLTU comparator.
// Walks a borrow-ripple subtraction a - b one bit per cycle, LSB first, then
// derives the less-than bit from the msb difference and the borrows around
// the msb. The result is the lt bit zero-extended to 32 bits.
// Optional feature: define SLT_EQ_FLAG_EN to add the serially accumulated
// 'eq' output (all difference bits zero).
module slt_seq_compare #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
`ifdef SLT_EQ_FLAG_EN
    output logic             eq,
`endif
    output logic [31:0]      result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q;
    logic             uns_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             d_msb_q, bin_msb_q, bout_msb_q;
    logic             lt_q;

    logic a_bit, b_bit, d_bit, borrow_next, last_bit, lt_new;

`ifdef SLT_EQ_FLAG_EN
    logic eq_acc_q, eq_q;
`endif

    // One step of the serial subtractor plus the signed/unsigned lt decision.
    always_comb begin
        a_bit       = a_q[cnt_q];
        b_bit       = b_q[cnt_q];
        d_bit       = a_bit ^ b_bit ^ borrow_q;
        borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
        last_bit    = (cnt_q == CW'(WIDTH - 1));
        // Signed: difference sign corrected by overflow (borrow in ^ borrow out of msb).
        lt_new      = uns_q ? bout_msb_q : (d_msb_q ^ bin_msb_q ^ bout_msb_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE waits for start, RUN walks WIDTH bits, FIN lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial borrow chain, msb bookkeeping and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            uns_q      <= 1'b0;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            d_msb_q    <= 1'b0;
            bin_msb_q  <= 1'b0;
            bout_msb_q <= 1'b0;
            lt_q       <= 1'b0;
`ifdef SLT_EQ_FLAG_EN
            eq_acc_q   <= 1'b0;
            eq_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        uns_q    <= is_unsigned;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
`ifdef SLT_EQ_FLAG_EN
                        eq_acc_q <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    borrow_q <= borrow_next;
                    cnt_q    <= cnt_q + CW'(1);
`ifdef SLT_EQ_FLAG_EN
                    eq_acc_q <= eq_acc_q & ~d_bit;
`endif
                    if (last_bit) begin
                        d_msb_q    <= d_bit;
                        bin_msb_q  <= borrow_q;
                        bout_msb_q <= borrow_next;
                    end
                end
                FIN: begin
                    lt_q <= lt_new;
`ifdef SLT_EQ_FLAG_EN
                    eq_q <= eq_acc_q;
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs: the fresh decision is presented during FIN alongside done,
    // and the held copy is shown at all other times.
    always_comb begin
        busy   = (state == RUN);
        done   = (state == FIN);
        lt     = done ? lt_new : lt_q;
        result = {31'b0, lt};
`ifdef SLT_EQ_FLAG_EN
        eq     = done ? eq_acc_q : eq_q;
`endif
    end

endmodule

// File: tb/tb_slt_seq_compare.sv
// tb_slt_seq_compare: randomized scoreboard bench for slt_seq_compare.
// Expected values come from plain signed/unsigned comparisons of the operands.
module tb_slt_seq_compare;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_unsigned;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         lt;
    logic [31:0]  result;
`ifdef SLT_EQ_FLAG_EN
    logic         eq;
`endif

    slt_seq_compare #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_unsigned (is_unsigned),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
`ifdef SLT_EQ_FLAG_EN
        .eq          (eq),
`endif
        .result      (result)
    );

    typedef struct {
        logic lt;
        logic eq;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   run_start = -10;
    int   run_end = -10;
    logic hold_lt = 1'b0;
    logic hold_eq = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares every presented result against the scoreboard head and
    // checks busy and the held outputs on all other cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'b0, busy}, {31'b0, (cyc >= run_start && cyc <= run_end)});
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("lt", {31'b0, lt}, {31'b0, e.lt});
                    chk("result", result, {31'b0, e.lt});
`ifdef SLT_EQ_FLAG_EN
                    chk("eq", {31'b0, eq}, {31'b0, e.eq});
`endif
                    hold_lt = e.lt;
                    hold_eq = e.eq;
                end
            end else begin
                chk("lt_hold", {31'b0, lt}, {31'b0, hold_lt});
                chk("result_hold", result, {31'b0, hold_lt});
`ifdef SLT_EQ_FLAG_EN
                chk("eq_hold", {31'b0, eq}, {31'b0, hold_eq});
`endif
            end
        end
    end

    function automatic logic model_lt(input logic [W-1:0] av, input logic [W-1:0] bv, input logic u);
        if (u) return (av < bv);
        return ($signed(av) < $signed(bv));
    endfunction

    // Issues one compare in the current cycle and returns in the first cycle
    // where the next start must be accepted. inj=1 pulses a stray start at
    // T+5, inj=2 pulses one during the done cycle.
    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic u, input int inj);
        int   t;
        exp_t e;
        t = cyc;
        a = av;
        b = bv;
        is_unsigned = u;
        start = 1'b1;
        e.lt  = model_lt(av, bv, u);
        e.eq  = (av == bv);
        e.cyc = t + W + 1;
        sb_q.push_back(e);
        run_start = t + 1;
        run_end   = t + W;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_unsigned = 1'($urandom);
        for (int k = 2; k <= W + 1; k++) begin
            @(posedge clk); #1;
            if ((inj == 1 && cyc == t + 5) || (inj == 2 && cyc == t + W + 1)) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
                is_unsigned = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        is_unsigned = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_lt", {31'b0, lt}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1;
        chk("rst_start_ignored", {31'b0, busy}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmp(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0);
        do_cmp(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        do_cmp(32'h8000_0000, 32'h0000_0001, 1'b0, 1);
        do_cmp(32'h8000_0000, 32'h0000_0001, 1'b1, 2);
        do_cmp(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        do_cmp(32'h1234_5678, 32'h1234_5678, 1'b1, 1);
        do_cmp(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0);
        do_cmp(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);
        do_cmp(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        do_cmp(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0);

        // Reset in the middle of a compare: no done, outputs cleared.
        t = cyc;
        a = 32'h0000_0000;
        b = 32'h0000_0001;
        is_unsigned = 1'b1;
        start = 1'b1;
        run_start = t + 1;
        run_end   = t + W;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        run_start = -10;
        run_end   = -10;
        hold_lt = 1'b0;
        hold_eq = 1'b0;
        #1;
        chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
        chk("midrun_rst_done", {31'b0, done}, 32'd0);
        chk("midrun_rst_lt", {31'b0, lt}, 32'd0);
        chk("midrun_rst_result", result, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_cmp(32'd3, 32'd5, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb[W-1] = ~ra[W-1];
            do_cmp(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("missing_done", 32'd0, 32'd1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/slt_seq_compare.md
SLT_SEQ_COMPARE -- requirements
Module: slt_seq_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a compare; sampled only in IDLE.
REQ-005 SHALL have port is_unsigned, input, 1, 1 = SLTU semantics, 0 = SLT semantics; captured with start.
REQ-006 SHALL have port a, input, WIDTH, rs operand; captured with start.
REQ-007 SHALL have port b, input, WIDTH, rt operand; captured with start.
REQ-008 SHALL have port busy, output, 1, high while a compare is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse when lt/result become valid.
REQ-010 SHALL have port lt, output, 1, comparison bit (a < b); the msb feeding the zero-extender.
REQ-011 SHALL have port result, output, 32, lt zero-extended: result[0] = lt, result[31:1] = 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIN.
REQ-013 IDLE: start=1 -> capture a, b, is_unsigned; clear borrow, bit counter and the eq accumulator (when present); go to RUN; busy=1 from the next cycle.
REQ-014 RUN: SHALL process one bit per cycle, LSB first: d = a[i]^b[i]^borrow; borrow_next = (~a[i]&b[i]) | (~(a[i]^b[i])&borrow).
REQ-015 RUN SHALL last exactly WIDTH cycles; at bit WIDTH-1 it SHALL record d_msb, the borrow into the msb and the borrow out of the msb, then go to FIN.
REQ-016 FIN: SHALL update lt and result, assert done for exactly one cycle, deassert busy, and go to IDLE.
REQ-017 Unsigned: lt = borrow out of the msb.
REQ-018 Signed: lt = d_msb XOR (borrow into msb XOR borrow out of msb), i.e. the difference sign corrected for overflow.
REQ-019 Latency: start sampled in cycle T -> done high in cycle T+WIDTH+1; next start accepted in cycle T+WIDTH+2.
REQ-020 start while busy=1 or in FIN SHALL be ignored; captured operands SHALL NOT change.
REQ-021 Input changes on a, b, is_unsigned after capture SHALL NOT affect the in-flight compare.
REQ-022 lt and result SHALL hold their last value until the next FIN; they SHALL NOT change during RUN.
REQ-023 a == b SHALL yield lt=0 in both modes.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, lt=0, result=0, and clear borrow, bit counter and the captured operands.
REQ-025 Reset asserted mid-RUN SHALL abort the compare with no done pulse; the first start after release begins a fresh compare.
REQ-026 start SHALL be ignored while rst_n is low.

Configuration
REQ-027 Macro SLT_EQ_FLAG_EN defined: SHALL add output eq, 1 bit, = 1 when all WIDTH difference bits are 0, accumulated serially and updated in FIN with lt. It SHALL reset to 0 and hold like lt.
REQ-028 Macro SLT_EQ_FLAG_EN undefined: SHALL have no eq port and no eq accumulator logic; all other behaviour is identical.

Verification
REQ-029 Unsigned: a=0x00000001, b=0xFFFFFFFF, is_unsigned=1 -> done at T+33, lt=1, result=0x00000001.
REQ-030 Signed: same operands, is_unsigned=0 -> lt=0, result=0x00000000.
REQ-031 Signed overflow: a=0x80000000, b=0x00000001, is_unsigned=0 -> lt=1; the same operands with is_unsigned=1 -> lt=0.
REQ-032 Equal operands: a=b=0x12345678 in both modes -> lt=0; eq=1 when SLT_EQ_FLAG_EN is defined.
REQ-033 start pulsed again at T+5 with different operands -> ignored; the T+33 result matches the first operands; a new start at T+34 is accepted.
REQ-034 rst_n pulled low at T+10 -> busy=0, done never pulses, lt=0, result=0; after release, a=3, b=5, is_unsigned=1 -> lt=1 after WIDTH+1 cycles.
